// File: rtl/uart_pkg.sv
// uart_pkg: bit timing shared with the transmitter and the receiver state encoding.
package uart_pkg;
    localparam int CYCLES_PER_BIT_DEFAULT = 10416;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial input plus received-byte port of the UART receiver.
interface uart_byte_rx_if;
    logic       uart_rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    modport master (input uart_rx, output data, valid, frame_err, busy);
    modport slave (output uart_rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer plus history flop, flags a falling edge on the line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic rx_s,
    output logic fall
);
    logic s1, s2, hist;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= 1'b1;
        end else begin
            s1   <= uart_rx;
            s2   <= s1;
            hist <= s2;
        end
    end
    assign rx_s = s2;
    assign fall = hist & ~s2;
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver sampling at mid-bit; one-cycle valid / frame_err strobes.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input logic             clk,
    input logic             rst,
    uart_byte_rx_if.master  bus
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    rx_state_t   state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh, data_q;
    logic        valid_q, err_q;
    logic        rx_s, fall, half_hit, bit_hit, samp, ok, bad;
    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (bus.uart_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );
    assign half_hit = cnt == CW'(HALF_BIT - 1);
    assign bit_hit  = cnt == CW'(CYCLES_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  nxt = fall ? START : IDLE;
            START: nxt = half_hit ? (rx_s ? IDLE : DATA) : START;
            DATA:  nxt = (bit_hit && idx == 3'd7) ? STOP : DATA;
            STOP:  nxt = bit_hit ? IDLE : STOP;
        endcase
    end
    always_comb begin
        samp = state == DATA && bit_hit;
        ok   = state == STOP && bit_hit && rx_s;
        bad  = state == STOP && bit_hit && !rx_s;
    end
    // counter restarts on every state change and after each data sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt     <= (state == IDLE || nxt != state || samp) ? '0 : cnt + CW'(1);
            idx     <= samp ? idx + 3'd1 : idx;
            sh      <= samp ? {rx_s, sh[7:1]} : sh;
            data_q  <= ok ? sh : data_q;
            valid_q <= ok;
            err_q   <= bad;
        end
    end
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frames with a scoreboard of expected strobes.
module tb_uart_byte_rx;
    localparam int C = 16;
    localparam int H = 8;
    typedef struct {
        logic       err;
        logic [7:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q[$];
    int   vtimes[$];
    uart_byte_rx_if bus ();
    uart_byte_rx #(.CYCLES_PER_BIT(C), .HALF_BIT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic line_bit(input logic v);
        bus.uart_rx = v;
        repeat (C) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
    endtask
    task automatic expect_byte(input logic err, input logic [7:0] d);
        exp_t e;
        e.err = err;
        e.d   = d;
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (bus.valid || bus.frame_err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h", bus.valid, bus.frame_err, bus.data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({bus.valid, bus.frame_err} !== (e.err ? 2'b01 : 2'b10) || bus.data !== e.d) begin
                    errors++;
                    $display("FAIL strobe: valid=%0b frame_err=%0b data=%0h expected err=%0b data=%0h",
                             bus.valid, bus.frame_err, bus.data, e.err, e.d);
                end
            end
            if (bus.valid) vtimes.push_back(cyc);
        end
    end
    initial begin
        string s;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", {24'd0, bus.data}, 32'h00);
        chk("reset_valid", {31'd0, bus.valid}, 0);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        // single good frame
        expect_byte(1'b0, 8'h68);
        send(8'h68, 1'b1);
        repeat (20) @(negedge clk);
        chk("t1_busy_idle", {31'd0, bus.busy}, 0);
        // short low glitch is rejected at the start-bit mid-sample
        bus.uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_busy_during", {31'd0, bus.busy}, 1);
        repeat (H + 4) @(negedge clk);
        chk("t2_busy_after", {31'd0, bus.busy}, 0);
        // bad stop bit with the line parked low
        expect_byte(1'b1, 8'h68);
        send(8'h32, 1'b0);
        repeat (40 - C) @(negedge clk);
        chk("t3_no_retrigger", {31'd0, bus.busy}, 0);
        chk("t3_data_kept", {24'd0, bus.data}, 32'h68);
        bus.uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        // back-to-back "hi"
        vtimes.delete();
        expect_byte(1'b0, 8'h68);
        expect_byte(1'b0, 8'h69);
        send(8'h68, 1'b1);
        send(8'h69, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_pulse_count", vtimes.size(), 2);
        if (vtimes.size() == 2) begin
            checks++;
            if (vtimes[1] - vtimes[0] < 10 * C - 1 || vtimes[1] - vtimes[0] > 10 * C + 1) begin
                errors++;
                $display("FAIL t4_spacing: got %0d expected %0d+-1", vtimes[1] - vtimes[0], 10 * C);
            end
        end
        // reset during the 4th data bit of 0x7A
        bus.uart_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) line_bit(8'h7A >> i);
        bus.uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_busy_mid", {31'd0, bus.busy}, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_data_reset", {24'd0, bus.data}, 32'h00);
        chk("t5_busy_reset", {31'd0, bus.busy}, 0);
        rst = 1'b1;
        repeat (3 * C) @(negedge clk);
        chk("t5_idle_after", {31'd0, bus.busy}, 0);
        expect_byte(1'b0, 8'h31);
        send(8'h31, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_data_new", {24'd0, bus.data}, 32'h31);
        // transmitter-style string stream
        s = "hitsz2024311278";
        for (int i = 0; i < s.len(); i++) expect_byte(1'b0, s[i]);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue", q.size(), 0);
        chk("final_data", {24'd0, bus.data}, 32'h38);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial receiver for the UART link driven by the string-transmit top level. It samples an asynchronous 8N1 line at the same bit period the transmitter uses (100 MHz clock, ~9600 baud). Each received byte is presented on a parallel port with a one-cycle valid strobe, and a separate one-cycle error strobe flags a bad stop bit. It is the downstream counterpart of the transmitter: loopback tests and on-board echo logic consume its output.

## Interface
- `CYCLES_PER_BIT`, default 10416: clock cycles per bit, matching the transmitter's bit period.
- `HALF_BIT`, default `CYCLES_PER_BIT/2`: cycles from the start edge to the start-bit mid-sample.
- `clk` in 1: 100 MHz system clock; all logic on the rising edge.
- `rst` in 1: asynchronous reset, active-low (`rst`=0 resets immediately); released synchronously by the board.
- `uart_rx` in 1: serial line; idle high; asynchronous to `clk`.
- `data` out 8: last correctly framed byte, LSB received first.
- `valid` out 1: one-cycle pulse; `data` is updated on the same edge.
- `frame_err` out 1: one-cycle pulse when the stop bit samples 0.
- `busy` out 1: high while a frame is in progress (START, DATA, STOP).

## Operation
- Input conditioning:
  - Two-flop synchronizer on `uart_rx`, then one history flop.
  - All three flops reset to 1.
  - A start edge is history=1 and synchronized=0. The block reacts to a falling edge, not a low level, so a line held low never retriggers.
- Counters:
  - Baud counter is `$clog2(CYCLES_PER_BIT)` bits wide and counts up from 0.
  - Bit index is 3 bits.
- States:
  - IDLE: counter held at 0. On a start edge go to START.
  - START: count to HALF_BIT-1. At that count, if the synchronized line is 0, clear the counter and go to DATA. If it is 1, the event is a glitch: go to IDLE with no strobes.
  - DATA: count to CYCLES_PER_BIT-1. At that count, shift the synchronized bit into bit 7 of the shift register (right shift), clear the counter, and increment the bit index. After the 8th sample (index wraps 7→0) go to STOP.
  - STOP: count to CYCLES_PER_BIT-1 and sample once.
    - Sample 1: `data`←shift register and `valid`=1.
    - Sample 0: `frame_err`=1 and `data` unchanged.
    - In both cases return to IDLE that cycle, which is mid-stop-bit, so a back-to-back start edge is caught.
- `valid` and `frame_err` are mutually exclusive and never exceed one cycle.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame aborts the frame with no strobe. After release, a new falling edge is required to start a frame.

## Timing
- Synchronizer latency is 2 cycles; edge detect adds 1 cycle.
- From the first `clk` edge that sees `uart_rx`=0 until `valid` goes high: 3 + HALF_BIT + 9·CYCLES_PER_BIT cycles, ±1 depending on where the asynchronous edge falls relative to `clk`.
- `busy` rises the cycle after the start edge is detected. It falls on the same edge that issues `valid` or `frame_err`, or at glitch rejection.
- Consecutive `valid` pulses for back-to-back frames are 10·CYCLES_PER_BIT cycles apart (±1).
- The receiver tolerates ±4% baud mismatch because sampling is at mid-bit.

## Structure
- Shared package `uart_pkg` holds:
  - `CYCLES_PER_BIT_DEFAULT` = 10416, which the transmitter also uses.
  - the state encoding constants IDLE/START/DATA/STOP (2 bits).
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus the history flop, outputting `rx_s` and `fall`.
- Everything else lives in the top module: FSM, counters, shift register.

## Test plan
All scenarios use `CYCLES_PER_BIT`=16 and `HALF_BIT`=8.
1. Send a single frame of 0x68 ('h') with a good stop bit → exactly one `valid` pulse, `data`=0x68, `frame_err` stays 0, `busy` low afterwards.
2. Drive a 4-cycle low glitch on an idle line → no `valid`, no `frame_err`; `busy` returns to 0 within HALF_BIT+4 cycles.
3. Send frame 0x32 with the stop bit forced to 0 and the line then held low for 40 cycles → one `frame_err` pulse, `data` keeps its previous value, no retrigger until the line goes high and falls again.
4. Send "hi" back-to-back (0x68, 0x69, no idle gap) → two `valid` pulses 160±1 cycles apart, carrying 0x68 then 0x69.
5. Assert `rst`=0 during the 4th data bit of 0x7A, release it, then send 0x31 → no strobe for the aborted frame, `data`=0x00 after reset, then `valid` with `data`=0x31.
6. Loopback from the transmitter top sending "hitsz2024311278" → 15 `valid` pulses in order with byte values matching the ASCII string, zero `frame_err` pulses.
